// File: rtl/mc_sequencer.sv
// Multi-cycle control sequencer: walks FETCH/DECODE/EXEC/MEM/WB per instruction
// and drives the datapath enables from the current state and the latched opcode.
module mc_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] opcode,
  input  logic       zero,
  input  logic       lt,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_sel,
  output logic       reg_we,
  output logic [1:0] data_sel,
  output logic [2:0] alu_op,
  output logic       alu_src,
  output logic [2:0] state,
  output logic       illegal
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  localparam logic [4:0] OP_LUI  = 5'd14;
  localparam logic [4:0] OP_LW   = 5'd15;
  localparam logic [4:0] OP_SW   = 5'd16;
  localparam logic [4:0] OP_BLT  = 5'd17;
  localparam logic [4:0] OP_BEQ  = 5'd18;
  localparam logic [4:0] OP_JAL  = 5'd19;
  localparam logic [4:0] OP_JALR = 5'd20;

  state_t     r_state;
  state_t     w_next;
  logic [4:0] r_op_q;
  logic       w_isAlu;
  logic       w_illegalOp;
  logic [2:0] w_aluCode;
  logic       w_aluRegForm;

  // Opcode is only trusted in DECODE; later states work from r_op_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= FETCH;
      r_op_q  <= 5'd0;
    end else begin
      r_state <= w_next;
      if (r_state == DECODE) begin
        r_op_q <= opcode;
      end
    end
  end

  assign state       = r_state;
  assign w_isAlu     = (r_op_q >= 5'd1) && (r_op_q <= 5'd13);
  assign w_illegalOp = (opcode == 5'd0) || (opcode > OP_JALR);

  always_comb begin
    w_aluCode    = 3'd0;
    w_aluRegForm = 1'b0;
    case (r_op_q)
      5'd1:  begin w_aluCode = 3'd1; w_aluRegForm = 1'b1; end
      5'd2:        w_aluCode = 3'd1;
      5'd3:  begin w_aluCode = 3'd2; w_aluRegForm = 1'b1; end
      5'd4:  begin w_aluCode = 3'd3; w_aluRegForm = 1'b1; end
      5'd5:        w_aluCode = 3'd3;
      5'd6:  begin w_aluCode = 3'd4; w_aluRegForm = 1'b1; end
      5'd7:        w_aluCode = 3'd4;
      5'd8:  begin w_aluCode = 3'd5; w_aluRegForm = 1'b1; end
      5'd9:        w_aluCode = 3'd5;
      5'd10: begin w_aluCode = 3'd6; w_aluRegForm = 1'b1; end
      5'd11:       w_aluCode = 3'd6;
      5'd12: begin w_aluCode = 3'd7; w_aluRegForm = 1'b1; end
      5'd13:       w_aluCode = 3'd7;
      default: ;
    endcase
  end

  always_comb begin
    w_next   = FETCH;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = 2'b00;
    reg_we   = 1'b0;
    data_sel = 2'b00;
    alu_op   = 3'b000;
    alu_src  = 1'b0;
    illegal  = 1'b0;
    case (r_state)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we  = 1'b1;
          pc_we  = 1'b1;
          w_next = DECODE;
        end else begin
          w_next = FETCH;
        end
      end
      DECODE: begin
        if (w_illegalOp) begin
          illegal = 1'b1;
          w_next  = FETCH;
        end else begin
          w_next = EXEC;
        end
      end
      EXEC: begin
        if (w_isAlu) begin
          alu_op  = w_aluCode;
          alu_src = w_aluRegForm;
          w_next  = WB;
        end else begin
          case (r_op_q)
            OP_LUI: w_next = WB;
            OP_LW, OP_SW: begin
              alu_op = 3'd1;
              w_next = MEM;
            end
            OP_BLT: begin
              alu_op  = 3'd2;
              alu_src = 1'b1;
              pc_sel  = 2'b01;
              pc_we   = lt;
            end
            OP_BEQ: begin
              alu_op  = 3'd2;
              alu_src = 1'b1;
              pc_sel  = 2'b01;
              pc_we   = zero;
            end
            OP_JAL: begin
              reg_we   = 1'b1;
              data_sel = 2'b11;
              pc_we    = 1'b1;
              pc_sel   = 2'b10;
            end
            OP_JALR: begin
              reg_we   = 1'b1;
              data_sel = 2'b11;
              pc_we    = 1'b1;
              pc_sel   = 2'b11;
              alu_op   = 3'd1;
            end
            default: w_next = FETCH;
          endcase
        end
      end
      MEM: begin
        mem_req = 1'b1;
        mem_we  = (r_op_q == OP_SW);
        alu_op  = 3'd1;
        if (!mem_ready) begin
          w_next = MEM;
        end else if (r_op_q == OP_LW) begin
          w_next = WB;
        end else begin
          w_next = FETCH;
        end
      end
      WB: begin
        reg_we = 1'b1;
        if (r_op_q == OP_LUI) begin
          data_sel = 2'b01;
        end else if (r_op_q == OP_LW) begin
          data_sel = 2'b10;
        end
      end
      default: w_next = FETCH;
    endcase
    // Reset must drop every strobe at once, even mid-access, without waiting for a clock.
    if (rst) begin
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      ir_we    = 1'b0;
      pc_we    = 1'b0;
      pc_sel   = 2'b00;
      reg_we   = 1'b0;
      data_sel = 2'b00;
      alu_op   = 3'b000;
      alu_src  = 1'b0;
      illegal  = 1'b0;
    end
  end

endmodule
